// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Bit counter must hold WIDTH-1; at least one bit for the WIDTH=2 corner.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done bus between an issuing controller (master) and the divider (slave).
// Handshake: start is taken on a rising edge only while ready=1; done pulses for one
// cycle when results are valid, and ready is already 1 in that cycle (back-to-back issue).
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the carry of the shift visible to the compare.
  assign shifted = {rem_in, next_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned operands,
// with divide-by-zero and MIN/-1 overflow flags; results hold until the next operation.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SIGNED_MODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_if.slave    bus,
  output div_state_e      dbg_state
);
  localparam int CW = cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;       // dividend bits shift out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dsr;      // |divisor|
  logic [WIDTH-1:0] rem;
  logic             a_neg, b_neg;
  logic             fix_done;
  logic             done_r;
  logic [WIDTH-1:0] q_res, r_res;
  logic             dz_res, ov_res;

  logic             accept;
  logic             ready_c;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             a_sign_in, b_sign_in;

  assign a_sign_in = (SIGNED_MODE != 0) && bus.dividend[WIDTH-1];
  assign b_sign_in = (SIGNED_MODE != 0) && bus.divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .next_bit (dq[WIDTH-1]),
    .divisor  (dsr),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (bus.divisor == '0) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; the cycle between FIX and done still counts as busy.
  always_comb begin
    ready_c = (state == ST_IDLE) && !fix_done;
    accept  = ready_c && bus.start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dq       <= '0;
      dsr      <= '0;
      rem      <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      fix_done <= 1'b0;
      done_r   <= 1'b0;
      q_res    <= '0;
      r_res    <= '0;
      dz_res   <= 1'b0;
      ov_res   <= 1'b0;
    end else begin
      fix_done <= (state == ST_FIX);
      done_r   <= fix_done;
      case (state)
        ST_IDLE: if (accept) begin
          a_neg <= a_sign_in;
          b_neg <= b_sign_in;
          dq    <= a_sign_in ? -bus.dividend : bus.dividend;
          dsr   <= b_sign_in ? -bus.divisor  : bus.divisor;
          rem   <= '0;
          cnt   <= CW'(WIDTH - 1);
        end
        ST_CALC: begin
          rem <= step_rem;
          dq  <= {dq[WIDTH-2:0], step_q};
          cnt <= cnt - 1'b1;
        end
        ST_FIX: begin
          if (dsr == '0) begin
            // CALC was skipped, so dq still holds |dividend|.
            q_res  <= '1;
            r_res  <= a_neg ? -dq : dq;
            dz_res <= 1'b1;
            ov_res <= 1'b0;
          end else begin
            q_res  <= (a_neg ^ b_neg) ? -dq : dq;
            r_res  <= a_neg ? -rem : rem;
            dz_res <= 1'b0;
            // MIN / -1: magnitude quotient is exactly 2^(WIDTH-1) with |divisor| = 1.
            ov_res <= a_neg && b_neg && (dsr == WIDTH'(1)) &&
                      (dq == {1'b1, {(WIDTH-1){1'b0}}});
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = ready_c;
  assign bus.done        = done_r;
  assign bus.quotient    = q_res;
  assign bus.remainder   = r_res;
  assign bus.div_by_zero = dz_res;
  assign bus.overflow    = ov_res;
  assign dbg_state       = state;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 8-bit signed and 16-bit unsigned instances.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_state_e state8, state16;

  seq_divider_if #(.WIDTH(8))  bus8 ();
  seq_divider_if #(.WIDTH(16)) bus16 ();

  seq_divider #(.WIDTH(8), .SIGNED_MODE(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .dbg_state (state8)
  );

  seq_divider #(.WIDTH(16), .SIGNED_MODE(0)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .dbg_state (state16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus8.done && n < 40);
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus16.done && n < 60);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eov, input int elat);
    int n;
    @(negedge clk);
    bus8.start = 1'b1; bus8.dividend = a; bus8.divisor = b;
    @(posedge clk); #1;
    chk("accept8", 32'(bus8.ready), 32'(0));
    bus8.start = 1'b0;
    wait_done8(n);
    chk("lat8", 32'(n), 32'(elat));
    chk("q8", 32'(bus8.quotient), 32'(eq));
    chk("r8", 32'(bus8.remainder), 32'(er));
    chk("dz8", 32'(bus8.div_by_zero), 32'(edz));
    chk("ov8", 32'(bus8.overflow), 32'(eov));
    chk("ready_at_done8", 32'(bus8.ready), 32'(1));
    @(posedge clk); #1;
    chk("done_pulse8", 32'(bus8.done), 32'(0));
    chk("q_hold8", 32'(bus8.quotient), 32'(eq));
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input int elat);
    int n;
    @(negedge clk);
    bus16.start = 1'b1; bus16.dividend = a; bus16.divisor = b;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    wait_done16(n);
    chk("lat16", 32'(n), 32'(elat));
    chk("q16", 32'(bus16.quotient), 32'(eq));
    chk("r16", 32'(bus16.remainder), 32'(er));
    chk("dz16", 32'(bus16.div_by_zero), 32'(edz));
    chk("ov16", 32'(bus16.overflow), 32'(0));
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;

    bus8.start = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
    bus16.start = 1'b0; bus16.dividend = '0; bus16.divisor = '0;

    // Reset values
    #12;
    chk("rst_ready", 32'(bus8.ready), 32'(1));
    chk("rst_done", 32'(bus8.done), 32'(0));
    chk("rst_q", 32'(bus8.quotient), 32'(0));
    chk("rst_r", 32'(bus8.remainder), 32'(0));
    chk("rst_flags", 32'({bus8.div_by_zero, bus8.overflow}), 32'(0));
    chk("rst_state", 32'(state8), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;

    // Positive and negative dividends
    run8(8'h7E, 8'h20, 8'h03, 8'h1E, 1'b0, 1'b0, 10);
    run8(8'h82, 8'h20, 8'hFD, 8'hE2, 1'b0, 1'b0, 10);
    // Negative divisor and exact negative quotient
    run8(8'h7E, 8'hCE, 8'hFE, 8'h1A, 1'b0, 1'b0, 10);
    run8(8'h82, 8'hCE, 8'h02, 8'hE6, 1'b0, 1'b0, 10);
    run8(8'h87, 8'h0B, 8'hF5, 8'h00, 1'b0, 1'b0, 10);
    // Divide by zero and MIN / -1
    run8(8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 2);
    run8(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10);
    run8(8'hAB, 8'h00, 8'hFF, 8'hAB, 1'b1, 1'b0, 2);

    // Back-to-back: start held through two operations
    @(negedge clk);
    bus8.start = 1'b1; bus8.dividend = 8'h64; bus8.divisor = 8'h07;
    @(posedge clk); #1;
    bus8.dividend = 8'h9C; bus8.divisor = 8'h05;
    wait_done8(n);
    chk("b2b_lat1", 32'(n), 32'(10));
    chk("b2b_q1", 32'(bus8.quotient), 32'(8'h0E));
    chk("b2b_r1", 32'(bus8.remainder), 32'(8'h02));
    chk("b2b_ready", 32'(bus8.ready), 32'(1));
    @(posedge clk); #1;
    chk("b2b_accept2", 32'(bus8.ready), 32'(0));
    chk("b2b_state2", 32'(state8), 32'(ST_CALC));
    bus8.start = 1'b0;
    // Start pulsed mid-CALC must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.dividend = 8'h11; bus8.divisor = 8'h01;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(n);
    chk("b2b_lat2", 32'(n), 32'(6));
    chk("b2b_q2", 32'(bus8.quotient), 32'(8'hEC));
    chk("b2b_r2", 32'(bus8.remainder), 32'(8'h00));
    repeat (5) @(posedge clk); #1;
    chk("hold_q", 32'(bus8.quotient), 32'(8'hEC));
    chk("hold_done", 32'(bus8.done), 32'(0));
    chk("hold_ready", 32'(bus8.ready), 32'(1));

    // Asynchronous reset mid-CALC
    @(negedge clk);
    bus8.start = 1'b1; bus8.dividend = 8'h7E; bus8.divisor = 8'h20;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(bus8.ready), 32'(1));
    chk("arst_q", 32'(bus8.quotient), 32'(0));
    chk("arst_r", 32'(bus8.remainder), 32'(0));
    chk("arst_state", 32'(state8), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("arst_no_done", 32'(bus8.done), 32'(0));
    run8(8'h79, 8'h0B, 8'h0B, 8'h00, 1'b0, 1'b0, 10);

    // Unsigned 16-bit instance
    run16(16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0, 18);
    run16(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18);
    run16(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      run16(ra, rb, ra / rb, ra % rb, 1'b0, 18);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
